// File: rtl/sobel_window_gen_pkg.sv
// Shared constants for the Sobel window producer and the downstream kernel adder.
// Window slots are numbered 1..9 in raster order (top-left to bottom-right).
package sobel_window_gen_pkg;

  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned IMG_W_DEF  = 640;
  localparam int unsigned IMG_H_DEF  = 480;

  localparam int unsigned WIN_TL = 1;
  localparam int unsigned WIN_TC = 2;
  localparam int unsigned WIN_TR = 3;
  localparam int unsigned WIN_ML = 4;
  localparam int unsigned WIN_MC = 5;
  localparam int unsigned WIN_MR = 6;
  localparam int unsigned WIN_BL = 7;
  localparam int unsigned WIN_BC = 8;
  localparam int unsigned WIN_BR = 9;

  // Slot number for window row r (0=top) and column c (0=left).
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return 3 * r + c + 1;
  endfunction

endpackage

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out bundle of the Sobel window producer.
// slave is the producer side, master is the pixel source / window consumer side.
interface sobel_window_gen_if #(
  parameter int unsigned DATA_W = sobel_window_gen_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic [DATA_W-1:0] data1, data2, data3;
  logic [DATA_W-1:0] data4, data5, data6;
  logic [DATA_W-1:0] data7, data8, data9;
  logic              frame_done;

  modport master (
    output in_valid, in_data,
    input  out_valid, frame_done,
    input  data1, data2, data3, data4, data5, data6, data7, data8, data9
  );

  modport slave (
    input  in_valid, in_data,
    output out_valid, frame_done,
    output data1, data2, data3, data4, data5, data6, data7, data8, data9
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// Fixed-delay line FIFO: dout is the pixel written DEPTH enables ago.
// Single circular pointer serves both read and write; storage is never cleared.
module sobel_line_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 640
) (
  input  logic              clk,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  assign dout = mem[ptr];

  // >= rather than == so an out-of-range power-up pointer falls back into range.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
      ptr      <= (ptr >= PTR_LAST) ? '0 : ptr + PW'(1);
    end
  end
endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to 3x3 neighbourhood producer; one window per interior pixel,
// registered one clock after the bottom-right pixel is accepted.
module sobel_window_gen
  import sobel_window_gen_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = IMG_W_DEF,
  parameter int unsigned IMG_H  = IMG_H_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sobel_window_gen_if.slave  bus
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0_out;
  logic [DATA_W-1:0] lb1_out;
  logic [DATA_W-1:0] win [1:9];
  logic              win_ok;
  logic              last_pix;

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .en   (bus.in_valid),
    .din  (bus.in_data),
    .dout (lb0_out)
  );

  sobel_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .en   (bus.in_valid),
    .din  (lb0_out),
    .dout (lb1_out)
  );

  // Border mask: the first two rows and columns of each line never complete a window.
  assign win_ok   = (row >= RW'(2)) && (col >= CW'(2));
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      bus.out_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      for (int unsigned i = 1; i <= 9; i++) begin
        win[i] <= '0;
      end
    end else begin
      bus.out_valid  <= bus.in_valid && win_ok;
      bus.frame_done <= bus.in_valid && last_pix;
      if (bus.in_valid) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        for (int unsigned r = 0; r < 3; r++) begin
          win[win_idx(r, 0)] <= win[win_idx(r, 1)];
          win[win_idx(r, 1)] <= win[win_idx(r, 2)];
        end
        win[WIN_TR] <= lb1_out;
        win[WIN_MR] <= lb0_out;
        win[WIN_BR] <= bus.in_data;
      end
    end
  end

  // The window registers are the output registers.
  assign bus.data1 = win[WIN_TL];
  assign bus.data2 = win[WIN_TC];
  assign bus.data3 = win[WIN_TR];
  assign bus.data4 = win[WIN_ML];
  assign bus.data5 = win[WIN_MC];
  assign bus.data6 = win[WIN_MR];
  assign bus.data7 = win[WIN_BL];
  assign bus.data8 = win[WIN_BC];
  assign bus.data9 = win[WIN_BR];
endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: three instances (4x4, 5x3, 16x8) checked against a
// frame-array reference model through per-instance expected-window queues.
module tb_sobel_window_gen;
  localparam int unsigned DW = 12;
  localparam int unsigned WB = 9 * DW;

  typedef struct packed {
    logic [WB-1:0] w;
    logic          fd;
  } exp_t;

  typedef struct packed {
    logic [DW-1:0] pix;
    logic          ov;
    logic          fd;
    logic [WB-1:0] w;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_window_gen_if #(.DATA_W(DW)) bus0 ();
  sobel_window_gen_if #(.DATA_W(DW)) bus1 ();
  sobel_window_gen_if #(.DATA_W(DW)) bus2 ();

  sobel_window_gen #(.DATA_W(DW), .IMG_W(4), .IMG_H(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0));
  sobel_window_gen #(.DATA_W(DW), .IMG_W(5), .IMG_H(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1));
  sobel_window_gen #(.DATA_W(DW), .IMG_W(16), .IMG_H(8)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int win_cnt [3];
  logic [DW-1:0] img [3][8][16];
  int mr [3];
  int mc [3];
  int iw [3] = '{4, 5, 16};
  int ih [3] = '{4, 3, 8};
  vec_t tbl [16];

  task automatic check(input string name, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic qpush(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic mon(input int k, input logic ov, input logic fd, input logic [WB-1:0] got);
    exp_t e;
    if (ov) begin
      win_cnt[k]++;
      if (qsize(k) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_window dut%0d got=%h exp=none", k, got);
      end else begin
        qpop(k, e);
        check($sformatf("window_dut%0d", k), got, e.w);
        check($sformatf("frame_done_dut%0d", k), fd, e.fd);
      end
    end else begin
      check($sformatf("idle_frame_done_dut%0d", k), fd, 1'b0);
      if (qsize(k) != 0) begin
        total++;
        bad++;
        qpop(k, e);
        $display("FAIL missing_window dut%0d got=no_output exp=%h", k, e.w);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus0.out_valid, bus0.frame_done, {bus0.data1, bus0.data2, bus0.data3,
        bus0.data4, bus0.data5, bus0.data6, bus0.data7, bus0.data8, bus0.data9});
    mon(1, bus1.out_valid, bus1.frame_done, {bus1.data1, bus1.data2, bus1.data3,
        bus1.data4, bus1.data5, bus1.data6, bus1.data7, bus1.data8, bus1.data9});
    mon(2, bus2.out_valid, bus2.frame_done, {bus2.data1, bus2.data2, bus2.data3,
        bus2.data4, bus2.data5, bus2.data6, bus2.data7, bus2.data8, bus2.data9});
  end

  // Presents one input cycle to instance k (others idle) and updates the reference frame.
  task automatic drive(input int k, input logic v, input logic [DW-1:0] d);
    exp_t e;
    @(negedge clk);
    #2;
    bus0.in_valid = (k == 0) && v;
    bus1.in_valid = (k == 1) && v;
    bus2.in_valid = (k == 2) && v;
    bus0.in_data  = d;
    bus1.in_data  = d;
    bus2.in_data  = d;
    if (v) begin
      img[k][mr[k]][mc[k]] = d;
      if (mr[k] >= 2 && mc[k] >= 2) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[(8 - (i * 3 + j)) * DW +: DW] = img[k][mr[k] - 2 + i][mc[k] - 2 + j];
        e.fd = (mr[k] == ih[k] - 1) && (mc[k] == iw[k] - 1);
        qpush(k, e);
      end
      mc[k]++;
      if (mc[k] == iw[k]) begin
        mc[k] = 0;
        mr[k]++;
        if (mr[k] == ih[k]) mr[k] = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1'b0, DW'($urandom_range(0, 4095)));
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus0.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      mr[k] = 0;
      mc[k] = 0;
    end
    @(posedge clk);
    #1;
    check("reset_out_valid", bus0.out_valid, 1'b0);
    check("reset_frame_done", bus0.frame_done, 1'b0);
    check("reset_data", {bus0.data1, bus0.data2, bus0.data3, bus0.data4, bus0.data5,
          bus0.data6, bus0.data7, bus0.data8, bus0.data9}, '0);
    for (int i = 1; i < n; i++) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  function automatic logic [WB-1:0] win_of(input int base, input int c0);
    logic [WB-1:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(8 - (i * 3 + j)) * DW +: DW] = DW'(base + 4 * i + j + c0);
    return w;
  endfunction

  function automatic logic [WB-1:0] cur0();
    return {bus0.data1, bus0.data2, bus0.data3, bus0.data4, bus0.data5,
            bus0.data6, bus0.data7, bus0.data8, bus0.data9};
  endfunction

  initial begin
    bus0.in_valid = 1'b0; bus1.in_valid = 1'b0; bus2.in_valid = 1'b0;
    bus0.in_data  = '0;   bus1.in_data  = '0;   bus2.in_data  = '0;
    for (int k = 0; k < 3; k++) begin
      mr[k] = 0; mc[k] = 0; win_cnt[k] = 0;
    end

    for (int i = 0; i < 16; i++) tbl[i] = '{pix: DW'(i), ov: 1'b0, fd: 1'b0, w: '0};
    tbl[10].ov = 1'b1;
    tbl[10].w  = {12'd0, 12'd1, 12'd2, 12'd4, 12'd5, 12'd6, 12'd8, 12'd9, 12'd10};
    tbl[11].ov = 1'b1;
    tbl[11].w  = {12'd1, 12'd2, 12'd3, 12'd5, 12'd6, 12'd7, 12'd9, 12'd10, 12'd11};
    tbl[14].ov = 1'b1;
    tbl[14].w  = {12'd4, 12'd5, 12'd6, 12'd8, 12'd9, 12'd10, 12'd12, 12'd13, 12'd14};
    tbl[15].ov = 1'b1;
    tbl[15].fd = 1'b1;
    tbl[15].w  = {12'd5, 12'd6, 12'd7, 12'd9, 12'd10, 12'd11, 12'd13, 12'd14, 12'd15};

    pulse_reset(2);

    // Single frame, continuous input, checked cycle by cycle against the table.
    win_cnt[0] = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b1, tbl[i].pix);
      @(posedge clk);
      #1;
      check($sformatf("t1_valid_p%0d", i), bus0.out_valid, tbl[i].ov);
      check($sformatf("t1_fd_p%0d", i), bus0.frame_done, tbl[i].fd);
      if (tbl[i].ov) check($sformatf("t1_window_p%0d", i), cur0(), tbl[i].w);
    end
    idle(2);
    check("t1_count", win_cnt[0], 4);

    // Same frame with alternate idle cycles.
    win_cnt[0] = 0;
    for (int p = 0; p < 16; p++) begin
      drive(0, 1'b1, DW'(p));
      drive(0, 1'b0, DW'($urandom_range(0, 4095)));
    end
    idle(2);
    check("t2_count", win_cnt[0], 4);

    // Two frames back to back, second frame offset by 100.
    win_cnt[0] = 0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 16; p++) begin
        drive(0, 1'b1, DW'(f * 100 + p));
        if (f == 1 && p == 10) begin
          @(posedge clk);
          #1;
          check("t3_first_window", cur0(), win_of(100, 0));
        end
      end
    idle(2);
    check("t3_count", win_cnt[0], 8);

    // Reset part-way through a frame, then a clean frame offset by 200.
    for (int p = 0; p < 7; p++) drive(0, 1'b1, DW'(50 + p));
    pulse_reset(1);
    win_cnt[0] = 0;
    for (int p = 0; p < 16; p++) begin
      drive(0, 1'b1, DW'(200 + p));
      if (p == 10) begin
        @(posedge clk);
        #1;
        check("t4_first_window", cur0(), win_of(200, 0));
      end
    end
    idle(2);
    check("t4_count", win_cnt[0], 4);

    // 5x3 frames at full scale then zero.
    win_cnt[1] = 0;
    for (int p = 0; p < 15; p++) drive(1, 1'b1, 12'hFFF);
    for (int p = 0; p < 15; p++) drive(1, 1'b1, 12'h000);
    idle(2);
    check("t5_count", win_cnt[1], 6);

    // Random 16x8 frames with random gaps.
    win_cnt[2] = 0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < 128; p++) begin
        if ($urandom_range(0, 2) == 0) drive(2, 1'b0, DW'($urandom_range(0, 4095)));
        drive(2, 1'b1, DW'($urandom_range(0, 4095)));
      end
    idle(3);
    check("t6_count", win_cnt[2], 168);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
